// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the single-bus 32-bit datapath. Steps through
// fetch (T0-T2), decode and execute (T3-T7) one T-state per clock and drives
// every register-transfer strobe as a Moore function of the state and the IR.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : an undefined opcode at T2 halts the sequencer and sets the
//               sticky illegal_op flag (cleared only by reset).
//   undefined : undefined opcodes behave as nop; illegal_op is tied to 0.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   ir         in   IR contents: op [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   mem_ready  in   memory completes the current read/write this cycle
//   PCout, Zlowout, Zhighout, MDRout, Cout           out  bus-source enables
//   PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin   out  register loads
//   Rin, Rout  out  NREGS one-hot general-register load / bus enables
//   control    out  4-bit ALU operation code
//   IncPc      out  ALU PC-increment
//   read       out  MDR mux selects memory data
//   write      out  memory write strobe
//   run        out  processor running (not in RST or HALT)
//   illegal_op out  sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             Cout,
  output logic             PCin,
  output logic             MARin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [3:0]       control,
  output logic             IncPc,
  output logic             read,
  output logic             write,
  output logic             run,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_LAST = 5'b01000;
  localparam logic [4:0] OP_ADDI     = 5'b01001;
  localparam logic [4:0] OP_LD       = 5'b01010;
  localparam logic [4:0] OP_ST       = 5'b01011;
  localparam logic [4:0] OP_MUL      = 5'b01100;
  localparam logic [4:0] OP_DIV      = 5'b01101;
  localparam logic [4:0] OP_NOP      = 5'b11000;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  state_t r_state;
  state_t w_next_state;

  logic [4:0] w_opcode;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_is_alu, w_is_addi, w_is_ld, w_is_st, w_is_muldiv;
  logic       w_is_nop, w_is_halt, w_is_defined;
  logic       w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_ra        = ir[26:23];
  assign w_rb        = ir[22:19];
  assign w_rc        = ir[18:15];
  assign w_unused_ir = ^ir[14:0];

  assign w_is_alu     = (w_opcode <= OP_ALU_LAST);
  assign w_is_addi    = (w_opcode == OP_ADDI);
  assign w_is_ld      = (w_opcode == OP_LD);
  assign w_is_st      = (w_opcode == OP_ST);
  assign w_is_muldiv  = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
  assign w_is_nop     = (w_opcode == OP_NOP);
  assign w_is_halt    = (w_opcode == OP_HALT);
  assign w_is_defined = w_is_alu || w_is_addi || w_is_ld || w_is_st ||
                        w_is_muldiv || w_is_nop || w_is_halt;

  // Register-field to one-hot enable; fields beyond NREGS shift out to zero.
  function automatic logic [NREGS-1:0] f_onehot(input logic [3:0] idx);
    return {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RST;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_RST:  w_next_state = ST_T0;
      ST_T0:   w_next_state = ST_T1;
      ST_T1:   w_next_state = mem_ready ? ST_T2 : ST_T1;
      ST_T2: begin
        if (w_is_halt)     w_next_state = ST_HALT;
        else if (w_is_nop) w_next_state = ST_T0;
        else if (!w_is_defined) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_next_state = ST_HALT;
`else
          w_next_state = ST_T0;
`endif
        end
        else               w_next_state = ST_T3;
      end
      ST_T3:   w_next_state = ST_T4;
      ST_T4:   w_next_state = ST_T5;
      ST_T5:   w_next_state = (w_is_alu || w_is_addi) ? ST_T0 : ST_T6;
      ST_T6: begin
        if (w_is_ld)      w_next_state = mem_ready ? ST_T7 : ST_T6;
        else if (w_is_st) w_next_state = ST_T7;
        else              w_next_state = ST_T0;
      end
      ST_T7: begin
        // Only ld/st reach T7; ld always retires, st waits for the write.
        if (w_is_st) w_next_state = mem_ready ? ST_T0 : ST_T7;
        else         w_next_state = ST_T0;
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_RST;
    endcase
  end

  // NOTE: every output gets a default before the case so no path through the
  // block leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    control  = 4'b0000;
    IncPc    = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    run      = (r_state != ST_RST) && (r_state != ST_HALT);

    unique case (r_state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zin = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        Yin  = 1'b1;
        Rout = w_is_muldiv ? f_onehot(w_ra) : f_onehot(w_rb);
      end
      ST_T4: begin
        Zin = 1'b1;
        if (w_is_alu || w_is_muldiv) begin
          Rout    = w_is_muldiv ? f_onehot(w_rb) : f_onehot(w_rc);
          control = ir[30:27];
        end else begin
          // addi/ld/st: add the sign-extended constant to Y.
          Cout = 1'b1;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (w_is_alu || w_is_addi)  Rin   = f_onehot(w_ra);
        else if (w_is_ld || w_is_st) MARin = 1'b1;
        else                         LOin  = 1'b1;
      end
      ST_T6: begin
        if (w_is_ld) begin
          read = 1'b1; MDRin = 1'b1;
        end else if (w_is_st) begin
          Rout = f_onehot(w_ra); MDRin = 1'b1;
        end else begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
      end
      ST_T7: begin
        if (w_is_st) write = 1'b1;
        else begin
          MDRout = 1'b1; Rin = f_onehot(w_ra);
        end
      end
      default: ;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_illegal_op <= 1'b0;
    else if (r_state == ST_T2 && !w_is_defined) r_illegal_op <= 1'b1;
  end

  assign illegal_op = r_illegal_op;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
